// File: rtl/posit_construct_pipe_pkg.sv
// Shared posit definitions: default geometry, special encodings and the
// field bundle passed between extraction, the adder core and construction.
package posit_pkg;

   localparam int POSIT_N  = 8;
   localparam int POSIT_ES = 3;
   localparam int POSIT_RS = $clog2(POSIT_N);
   localparam int POSIT_FW = POSIT_N - POSIT_ES + 2;

   // Result fields; frac carries the hidden one in its MSB
   typedef struct packed {
      logic                     sign;
      logic [POSIT_RS+1:0]      regime;
      logic [POSIT_ES-1:0]      exp;
      logic [POSIT_N-POSIT_ES+2:0] frac;
      logic                     sticky;
      logic                     inf;
      logic                     zero;
   } posit_fields_t;

   // Not-a-Real: a one followed by n-1 zeros, right-aligned in 64 bits
   function automatic logic [63:0] nar(input int n);
      nar = 64'(1) << (n - 1);
   endfunction

   // Largest positive posit: zero sign bit followed by n-1 ones
   function automatic logic [63:0] maxpos(input int n);
      maxpos = (64'(1) << (n - 1)) - 64'(1);
   endfunction

endpackage

// File: rtl/posit_construct_pipe_if.sv
// Handshake and payload bundle around the posit construction pipeline.
// The slave side is the pipeline, the master side feeds and drains it.
interface posit_construct_pipe_if import posit_pkg::*; #(
   parameter int N  = POSIT_N,
   parameter int ES = POSIT_ES
);

   localparam int RS = $clog2(N);

   logic              in_valid;
   logic              in_ready;
   logic              in_sign;
   logic [RS+1:0]     in_regime;
   logic [ES-1:0]     in_exp;
   logic [N-ES+2:0]   in_frac;
   logic              in_sticky;
   logic              in_inf;
   logic              in_zero;

   logic              out_valid;
   logic              out_ready;
   logic [N-1:0]      out_posit;
   logic              out_inf;
   logic              out_zero;

   modport slave (
      input  in_valid, in_sign, in_regime, in_exp, in_frac, in_sticky, in_inf, in_zero,
      output in_ready,
      output out_valid, out_posit, out_inf, out_zero,
      input  out_ready
   );

   modport master (
      output in_valid, in_sign, in_regime, in_exp, in_frac, in_sticky, in_inf, in_zero,
      input  in_ready,
      input  out_valid, out_posit, out_inf, out_zero,
      output out_ready
   );

endinterface

// File: rtl/posit_construct_pipe_round.sv
// Final rounding step: round-to-nearest-even on the kept magnitude, posit
// saturation (never to zero or NaR), two's complement for negatives and the
// NaR / zero overrides.
module posit_round_rne import posit_pkg::*; #(
   parameter int N = POSIT_N
) (
   input  logic         sign,
   input  logic [N-2:0] kept,
   input  logic         guard,
   input  logic         sticky,
   input  logic         sat_max,
   input  logic         sat_min,
   input  logic         inf,
   input  logic         zero,
   output logic [N-1:0] posit,
   output logic         is_inf,
   output logic         is_zero
);

   localparam logic [N-1:0] NAR_CODE   = N'(nar(N));
   localparam logic [N-2:0] MAXPOS_MAG = (N-1)'(maxpos(N));
   localparam logic [N-2:0] MINPOS_MAG = {{(N-2){1'b0}}, 1'b1};

   logic         round_up;
   logic [N-1:0] sum;
   logic [N-2:0] mag;

   // Round the magnitude, clamp it into [minpos, maxpos], then apply sign and specials
   always_comb begin
      round_up = guard & (kept[0] | sticky);
      sum      = {1'b0, kept} + {{(N-1){1'b0}}, round_up};
      mag      = sum[N-2:0];
      if (sum[N-1]) begin
         mag = MAXPOS_MAG;
      end
      if (mag == '0) begin
         mag = MINPOS_MAG;
      end
      if (sat_max) begin
         mag = MAXPOS_MAG;
      end else if (sat_min) begin
         mag = MINPOS_MAG;
      end
      posit   = sign ? (~{1'b0, mag} + {{(N-1){1'b0}}, 1'b1}) : {1'b0, mag};
      is_inf  = 1'b0;
      is_zero = 1'b0;
      if (inf) begin
         posit  = NAR_CODE;
         is_inf = 1'b1;
      end else if (zero) begin
         posit   = '0;
         is_zero = 1'b1;
      end
   end

endmodule

// File: rtl/posit_construct_pipe.sv
// Packs sign/regime/exponent/fraction fields back into an N-bit posit.
// Stage 1 holds the incoming fields; the regime/exponent/fraction bit string
// is built and rounded from that register into the stage 2 output register.
module posit_construct_pipe import posit_pkg::*; #(
   parameter int N  = POSIT_N,
   parameter int ES = POSIT_ES,
   parameter int RS = $clog2(N)
) (
   input  logic                    clk,
   input  logic                    reset,
   posit_construct_pipe_if.slave   bus
);

   // Fraction bits after the hidden one, body = exponent + fraction
   localparam int FW = N - ES + 2;
   localparam int BW = ES + FW;
   // At least 2N, and wide enough that the longest regime pushes no body bit off the end
   localparam int SW = (2 * N > N - 1 + BW) ? 2 * N : N - 1 + BW;

   logic              s1_valid;
   logic              s1_sign;
   logic [RS+1:0]     s1_regime;
   logic [ES-1:0]     s1_exp;
   logic [FW-1:0]     s1_frac;
   logic              s1_sticky;
   logic              s1_inf;
   logic              s1_zero;
   logic              s1_advance;

   logic              s2_valid;
   logic [N-1:0]      s2_posit;
   logic              s2_inf;
   logic              s2_zero;

   int                k;
   int                reg_len;
   logic [SW-1:0]     body_vec;
   logic [SW-1:0]     str;
   logic [N-2:0]      kept;
   logic              guard;
   logic              sticky;
   logic              sat_max;
   logic              sat_min;

   logic [N-1:0]      rnd_posit;
   logic              rnd_inf;
   logic              rnd_zero;

   assign s1_advance    = ~s2_valid | bus.out_ready;
   assign bus.in_ready  = ~s1_valid | s1_advance;
   // A sync reset flushes everything, so nothing may be handed off in that cycle
   assign bus.out_valid = s2_valid & ~reset;
   assign bus.out_posit = s2_posit;
   assign bus.out_inf   = s2_inf;
   assign bus.out_zero  = s2_zero;

   // Stage 1 register: capture the fields whenever the stage can take a new entry
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s1_sign   <= 1'b0;
         s1_regime <= '0;
         s1_exp    <= '0;
         s1_frac   <= '0;
         s1_sticky <= 1'b0;
         s1_inf    <= 1'b0;
         s1_zero   <= 1'b0;
      end else if (bus.in_ready) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_sign   <= bus.in_sign;
            s1_regime <= bus.in_regime;
            s1_exp    <= bus.in_exp;
            s1_frac   <= bus.in_frac[FW-1:0];
            s1_sticky <= bus.in_sticky;
            s1_inf    <= bus.in_inf;
            s1_zero   <= bus.in_zero;
         end
      end
   end

   // Build regime|exponent|fraction MSB-first and split it into kept, guard and sticky
   always_comb begin
      k       = int'($signed(s1_regime));
      sat_max = (k >= N - 2);
      sat_min = (k < -(N - 2));
      if (k >= 0) begin
         reg_len = k + 2;
      end else begin
         reg_len = 1 - k;
      end
      if (reg_len > N - 1) begin
         reg_len = N - 1;
      end
      body_vec = {s1_exp, s1_frac, {(SW-BW){1'b0}}} >> reg_len;
      if (k >= 0) begin
         str = body_vec | ~({SW{1'b1}} >> (reg_len - 1));
      end else begin
         str = body_vec | ({1'b1, {(SW-1){1'b0}}} >> (reg_len - 1));
      end
      kept   = str[SW-1 -: N-1];
      guard  = str[SW-N];
      sticky = (|str[SW-N-1:0]) | s1_sticky;
   end

   posit_round_rne #(.N(N)) u_round (
      .sign    (s1_sign),
      .kept    (kept),
      .guard   (guard),
      .sticky  (sticky),
      .sat_max (sat_max),
      .sat_min (sat_min),
      .inf     (s1_inf),
      .zero    (s1_zero),
      .posit   (rnd_posit),
      .is_inf  (rnd_inf),
      .is_zero (rnd_zero)
   );

   // Stage 2 output register: load a rounded result when the consumer side frees up
   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid <= 1'b0;
         s2_posit <= '0;
         s2_inf   <= 1'b0;
         s2_zero  <= 1'b0;
      end else if (s1_advance) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_posit <= rnd_posit;
            s2_inf   <= rnd_inf;
            s2_zero  <= rnd_zero;
         end
      end
   end

endmodule
